// File: rtl/simd_loop_ctrl_pkg.sv
// Shared SIMD definitions for the loop controller.
// Holds the LOOP opcode/function codes, the fixed instruction field offsets and
// the controller state encoding. No ports; imported by simd_loop_ctrl.
package simd_loop_ctrl_pkg;

   // LOOP instruction encoding
   localparam logic [3:0] LoopOpcode   = 4'b0111;
   localparam logic [3:0] FnSetIter    = 4'b0000;
   localparam logic [3:0] FnSetNumInst = 4'b0001;

   // Instruction field LSB offsets within the 32-bit word
   localparam int unsigned OpcodeLsb       = 28;
   localparam int unsigned FnLsb           = 24;
   localparam int unsigned DestNsIdLsb     = 21;
   localparam int unsigned DestNsIndexLsb  = 16;
   localparam int unsigned Src1NsIdLsb     = 13;
   localparam int unsigned Src1NsIndexLsb  = 8;
   localparam int unsigned Src2NsIdLsb     = 5;
   localparam int unsigned Src2NsIndexLsb  = 0;
   localparam int unsigned ImmLsb          = 0;
   localparam int unsigned ImmBits         = 16;

   // Controller states
   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCapture = 2'd1;
   localparam logic [1:0] StReplay  = 2'd2;

   // True when inst is a LOOP instruction with the given function code.
   function automatic logic is_loop_fn(input logic [31:0] inst, input logic [3:0] fn_code);
      return (inst[OpcodeLsb +: 4] == LoopOpcode) && (inst[FnLsb +: 4] == fn_code);
   endfunction

endpackage

// File: rtl/simd_loop_buffer.sv
// Loop-body instruction buffer.
// One synchronous write port, one combinational read port; data is not reset.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (read).
module simd_loop_buffer #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [WIDTH-1:0]     rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simd_loop_ctrl.sv
// SIMD single-level loop controller.
// Passes instructions through to a registered output, captures a loop body of
// N instructions after SET_ITER/SET_NUM_INST and replays it count-1 more times.
// Ports: clk, reset (async, active high); inst_in/inst_valid/inst_ready input
// handshake; out_stall holds the output register; opcode..src2_ns_index_id are
// the registered instruction fields with out_valid/in_single_loop qualifiers;
// loop_busy (not idle) and loop_err (sticky body-length overflow).
module simd_loop_ctrl
   import simd_loop_ctrl_pkg::*;
#(
   parameter int unsigned NS_ID_BITS       = 3,
   parameter int unsigned NS_INDEX_ID_BITS = 5,
   parameter int unsigned OPCODE_BITS      = 4,
   parameter int unsigned FUNCTION_BITS    = 4,
   parameter int unsigned BODY_DEPTH       = 16,
   parameter int unsigned ITER_BITS        = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 inst_in,
   input  logic                        inst_valid,
   output logic                        inst_ready,
   input  logic                        out_stall,
   output logic [OPCODE_BITS-1:0]      opcode,
   output logic [FUNCTION_BITS-1:0]    fn,
   output logic [NS_ID_BITS-1:0]       dest_ns_id,
   output logic [NS_INDEX_ID_BITS-1:0] dest_ns_index_id,
   output logic [NS_ID_BITS-1:0]       src1_ns_id,
   output logic [NS_INDEX_ID_BITS-1:0] src1_ns_index_id,
   output logic [NS_ID_BITS-1:0]       src2_ns_id,
   output logic [NS_INDEX_ID_BITS-1:0] src2_ns_index_id,
   output logic                        out_valid,
   output logic                        in_single_loop,
   output logic                        loop_busy,
   output logic                        loop_err
);

   localparam int unsigned AddrBits = $clog2(BODY_DEPTH);

   logic [1:0]           state_q, state_d;
   logic [ITER_BITS-1:0] count_q, count_d;   // latched SET_ITER count, never 0
   logic [ITER_BITS-1:0] iter_q, iter_d;     // replay passes still to issue
   logic [AddrBits-1:0]  ptr_q, ptr_d;       // shared capture/replay pointer
   logic [AddrBits-1:0]  len_m1_q, len_m1_d; // body length minus one
   logic                 err_q, err_d;
   logic                 valid_q, valid_d;
   logic                 isl_q, isl_d;
   logic [31:0]          word_q, word_d;

   logic                 accept;
   logic                 buf_we;
   logic [31:0]          buf_rdata;
   logic [ImmBits-1:0]   imm;
   logic [ITER_BITS-1:0] imm_count;

   assign imm        = inst_in[ImmLsb +: ImmBits];
   assign imm_count  = ITER_BITS'(imm);
   assign inst_ready = !out_stall && ((state_q == StIdle) || (state_q == StCapture));
   assign accept     = inst_valid && inst_ready;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      iter_d   = iter_q;
      ptr_d    = ptr_q;
      len_m1_d = len_m1_q;
      err_d    = err_q;
      valid_d  = valid_q;
      isl_d    = isl_q;
      word_d   = word_q;
      buf_we   = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               // LOOP instructions are forwarded too; downstream gates buffers on them
               word_d  = inst_in;
               valid_d = 1'b1;
               isl_d   = 1'b0;
               if (is_loop_fn(inst_in, FnSetIter)) begin
                  count_d = (imm_count == '0) ? ITER_BITS'(1) : imm_count;
               end else if (is_loop_fn(inst_in, FnSetNumInst) && (imm != '0)) begin
                  state_d = StCapture;
                  ptr_d   = '0;
                  if (imm > ImmBits'(BODY_DEPTH)) begin
                     len_m1_d = AddrBits'(BODY_DEPTH - 1);
                     err_d    = 1'b1;
                  end else begin
                     len_m1_d = AddrBits'(imm - ImmBits'(1));
                  end
               end
            end else if (!out_stall) begin
               valid_d = 1'b0;
               isl_d   = 1'b0;
            end
         end

         StCapture: begin
            // Every accepted word is body, LOOP encodings included (no nesting)
            if (accept) begin
               word_d  = inst_in;
               valid_d = 1'b1;
               isl_d   = 1'b1;
               buf_we  = 1'b1;
               if (ptr_q == len_m1_q) begin
                  ptr_d = '0;
                  if (count_q > ITER_BITS'(1)) begin
                     state_d = StReplay;
                     iter_d  = count_q - ITER_BITS'(1);
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  ptr_d = ptr_q + AddrBits'(1);
               end
            end else if (!out_stall) begin
               valid_d = 1'b0;
               isl_d   = 1'b0;
            end
         end

         StReplay: begin
            if (!out_stall) begin
               word_d  = buf_rdata;
               valid_d = 1'b1;
               isl_d   = 1'b1;
               if (ptr_q == len_m1_q) begin
                  ptr_d = '0;
                  if (iter_q == ITER_BITS'(1)) begin
                     // Leave on the last issue so IDLE can accept next cycle
                     state_d = StIdle;
                     iter_d  = '0;
                  end else begin
                     iter_d = iter_q - ITER_BITS'(1);
                  end
               end else begin
                  ptr_d = ptr_q + AddrBits'(1);
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         count_q  <= ITER_BITS'(1);
         iter_q   <= '0;
         ptr_q    <= '0;
         len_m1_q <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         isl_q    <= 1'b0;
         word_q   <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         iter_q   <= iter_d;
         ptr_q    <= ptr_d;
         len_m1_q <= len_m1_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         isl_q    <= isl_d;
         word_q   <= word_d;
      end
   end

   simd_loop_buffer #(
      .DEPTH     (BODY_DEPTH),
      .WIDTH     (32),
      .ADDR_BITS (AddrBits)
   ) u_body_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (ptr_q),
      .wr_data (inst_in),
      .rd_addr (ptr_q),
      .rd_data (buf_rdata)
   );

   assign opcode           = word_q[OpcodeLsb +: OPCODE_BITS];
   assign fn               = word_q[FnLsb +: FUNCTION_BITS];
   assign dest_ns_id       = word_q[DestNsIdLsb +: NS_ID_BITS];
   assign dest_ns_index_id = word_q[DestNsIndexLsb +: NS_INDEX_ID_BITS];
   assign src1_ns_id       = word_q[Src1NsIdLsb +: NS_ID_BITS];
   assign src1_ns_index_id = word_q[Src1NsIndexLsb +: NS_INDEX_ID_BITS];
   assign src2_ns_id       = word_q[Src2NsIdLsb +: NS_ID_BITS];
   assign src2_ns_index_id = word_q[Src2NsIndexLsb +: NS_INDEX_ID_BITS];
   assign out_valid        = valid_q;
   assign in_single_loop   = isl_q;
   assign loop_busy        = (state_q != StIdle);
   assign loop_err         = err_q;

endmodule
